// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG word packer and its FIFO.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISCARD = 2'd1,
        COLLECT = 2'd2
    } packer_state_e;

    localparam int TRNG_WORD_W    = 32;
    localparam int TRNG_DISCARD_N = 64;
    localparam int TRNG_DEPTH     = 4;
    localparam int TRNG_RCT_LIMIT = 32;
    localparam int DROP_CNT_W     = 16;

    // Counter width for a count that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trng_word_packer_if.sv
// Output word port of the packer.
// Handshake: a word transfers in every cycle where valid && ready; while valid is
// high, data holds the FIFO head and stays stable until it is taken.
interface trng_word_packer_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/trng_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push and pop in the same cycle are
// legal even when full, leaving the occupancy unchanged.
module trng_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] fill
);
    import trng_pkg::*;

    localparam int PTR_W  = cnt_w(DEPTH);
    localparam int FILL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] count;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FILL_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + FILL_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - FILL_W'(1);
            end
        end
    end

    assign data  = mem[rd_ptr];
    assign valid = (count != '0);
    assign fill  = count;

endmodule

// File: rtl/trng_word_packer.sv
// Packs accepted raw TRNG bits MSB-first into words after a warm-up discard.
// Define TRNG_PACKER_HEALTH_EN to add the repetition-count health test.
module trng_word_packer
    import trng_pkg::*;
#(
    parameter int WORD_W    = TRNG_WORD_W,
    parameter int DEPTH     = TRNG_DEPTH,
    parameter int DISCARD_N = TRNG_DISCARD_N,
    parameter int RCT_LIMIT = TRNG_RCT_LIMIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run_en,
    input  logic                       bit_ce,
    input  logic                       rnd_bit,
    trng_word_packer_if.master         out,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       overflow,
    output logic [DROP_CNT_W-1:0]      drop_cnt,
    output logic                       health_fail,
    output packer_state_e              dbg_state
);

    localparam int DISC_W = cnt_w(DISCARD_N);
    localparam int BIT_W  = cnt_w(WORD_W);
    localparam int FILL_W = $clog2(DEPTH+1);
    localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'((DISCARD_N > 0) ? DISCARD_N - 1 : 0);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam packer_state_e START_STATE = (DISCARD_N == 0) ? COLLECT : DISCARD;

    packer_state_e     state;
    packer_state_e     eff_state;
    logic [DISC_W-1:0] disc_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-2:0] sr;
    logic [WORD_W-1:0] word_bits;
    logic              accept;
    logic              collect_acc;
    logic              rct_trip;
    logic              word_done;
    logic              pop;
    logic              push;
    logic              drop;

    // An accept in the cycle run_en rises is processed as if already in the target state.
    assign eff_state   = (state == IDLE) ? START_STATE : state;
    assign accept      = run_en && bit_ce;
    assign collect_acc = accept && (eff_state == COLLECT);
    assign word_bits   = {sr, rnd_bit};
    assign word_done   = collect_acc && (bit_cnt == BIT_LAST) && !rct_trip;
    assign pop         = out.valid && out.ready;
    assign drop        = word_done && (fill == FILL_W'(DEPTH)) && !pop;
    assign push        = word_done && !drop;

`ifdef TRNG_PACKER_HEALTH_EN
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);

    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] next_run_len;
    logic             last_bit;

    assign next_run_len = ((run_len == '0) || (rnd_bit != last_bit)) ? RUN_W'(1)
                                                                      : run_len + RUN_W'(1);
    assign rct_trip     = collect_acc && (next_run_len == RUN_W'(RCT_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_len     <= '0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (!run_en) begin
            run_len  <= '0;
            last_bit <= 1'b0;
        end else if (collect_acc) begin
            last_bit <= rnd_bit;
            run_len  <= rct_trip ? '0 : next_run_len;
            if (rct_trip) begin
                health_fail <= 1'b1;
            end
        end
    end
`else
    assign rct_trip    = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            disc_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (!run_en) begin
                state    <= IDLE;
                disc_cnt <= '0;
                bit_cnt  <= '0;
                sr       <= '0;
            end else begin
                state <= eff_state;
                case (eff_state)
                    DISCARD: begin
                        if (accept) begin
                            if (disc_cnt == DISC_LAST) begin
                                state    <= COLLECT;
                                disc_cnt <= '0;
                            end else begin
                                disc_cnt <= disc_cnt + DISC_W'(1);
                            end
                        end
                    end
                    COLLECT: begin
                        if (accept) begin
                            if (rct_trip) begin
                                sr      <= '0;
                                bit_cnt <= '0;
                            end else begin
                                sr      <= word_bits[WORD_W-2:0];
                                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign dbg_state = state;

    trng_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word_bits),
        .pop       (pop),
        .data      (out.data),
        .valid     (out.valid),
        .fill      (fill)
    );

endmodule

// File: tb/tb_trng_word_packer.sv
// Directed and randomized bench for trng_word_packer against a bit-list reference model.
module tb_trng_word_packer;
    import trng_pkg::*;

    localparam int WORD_W    = 32;
    localparam int DEPTH     = 4;
    localparam int DISCARD_N = 64;
    localparam int RCT_LIMIT = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          run_en;
    logic          bit_ce;
    logic          rnd_bit;
    logic [2:0]    fill;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          health_fail;
    packer_state_e dbg_state;

    trng_word_packer_if #(.WORD_W(WORD_W)) out_if ();

    trng_word_packer #(
        .WORD_W    (WORD_W),
        .DEPTH     (DEPTH),
        .DISCARD_N (DISCARD_N),
        .RCT_LIMIT (RCT_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .bit_ce      (bit_ce),
        .rnd_bit     (rnd_bit),
        .out         (out_if),
        .fill        (fill),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .health_fail (health_fail),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: words seen by the consumer plus run/partial-word bookkeeping.
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] m_word;
    int                m_acc;
    int                m_nbits;
    int                m_run_len;
    logic              m_last_bit;
    logic              m_overflow;
    int                m_drop;
    logic              m_health;
    int                n_vec;
    int                n_err;
    int                dut_pops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_word     = '0;
        m_acc      = 0;
        m_nbits    = 0;
        m_run_len  = 0;
        m_last_bit = 1'b0;
        m_overflow = 1'b0;
        m_drop     = 0;
        m_health   = 1'b0;
    endtask

    task automatic model_update(input logic run, input logic ce, input logic b, input logic rdy);
        logic pop_now;
        logic word_now;
        pop_now  = (exp_q.size() > 0) && rdy;
        word_now = 1'b0;
        if (!run) begin
            m_acc     = 0;
            m_nbits   = 0;
            m_word    = '0;
            m_run_len = 0;
        end else if (ce) begin
            if (m_acc < DISCARD_N) begin
                m_acc++;
            end else begin
                m_word = {m_word[WORD_W-2:0], b};
                m_nbits++;
`ifdef TRNG_PACKER_HEALTH_EN
                if (m_run_len > 0 && b == m_last_bit) m_run_len++;
                else m_run_len = 1;
                m_last_bit = b;
                if (m_run_len == RCT_LIMIT) begin
                    m_health  = 1'b1;
                    m_nbits   = 0;
                    m_run_len = 0;
                end
`endif
                if (m_nbits == WORD_W) begin
                    word_now = 1'b1;
                    m_nbits  = 0;
                end
            end
        end
        if (pop_now) void'(exp_q.pop_front());
        if (word_now) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(m_word);
            end else begin
                m_overflow = 1'b1;
                if (m_drop < 16'hFFFF) m_drop++;
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_if.valid), 32'(exp_q.size() > 0));
        chk("fill", 32'(fill), 32'(exp_q.size()));
        chk("overflow", 32'(overflow), 32'(m_overflow));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("health_fail", 32'(health_fail), 32'(m_health));
        if (exp_q.size() > 0) chk("out_data", out_if.data, exp_q[0]);
    endtask

    task automatic step(input logic r, input logic run, input logic ce, input logic b, input logic rdy);
        rst          = r;
        run_en       = run;
        bit_ce       = ce;
        rnd_bit      = b;
        out_if.ready = rdy;
        if (r) model_reset();
        else model_update(run, ce, b, rdy);
        if (!r && out_if.valid && rdy) dut_pops++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        dut_pops = 0;
        model_reset();

        // Reset held two cycles with run_en high.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("reset_data", out_if.data, 32'h0);

        // Strobe every 5th cycle, alternating bits starting with 1, consumer always ready.
        for (int a = 0; a < 130; a++) begin
            for (int k = 0; k < 4; k++) step(0, 1, 0, 1'($urandom_range(0, 1)), 1);
            step(0, 1, 1, (a % 2 == 0), 1);
            if (a == 94) chk("no_word_before_96", 32'(out_if.valid), 32'h0);
            if (a == 95) begin
                chk("first_word_valid", 32'(out_if.valid), 32'h1);
                chk("first_word", out_if.data, 32'hAAAAAAAA);
            end
        end
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 1);
        chk("cadence_word_count", 32'(dut_pops), 32'(2));

        // Overflow: five words completed while the consumer stalls.
        for (int a = 0; a < 5 * WORD_W; a++) step(0, 1, 1, 1'($urandom_range(0, 1)), 0);
        chk("ovf_fill", 32'(fill), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1);
        chk("ovf_drained", 32'(out_if.valid), 32'h0);

        // Completion coinciding with a pop while full.
        step(1, 0, 0, 0, 0);
        for (int a = 0; a < DISCARD_N + 4 * WORD_W + 8 && exp_q.size() < DEPTH; a++)
            step(0, 1, 1, 1'($urandom_range(0, 1)), 0);
        chk("full_fill", 32'(fill), 32'd4);
        for (int a = 0; a < WORD_W && m_nbits != WORD_W - 1; a++)
            step(0, 1, 1, 1'($urandom_range(0, 1)), 0);
        step(0, 1, 1, 1'($urandom_range(0, 1)), 1);
        chk("pushpop_fill", 32'(fill), 32'd4);
        chk("pushpop_overflow", 32'(overflow), 32'h0);

        // Run abort mid-word; FIFO contents survive.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int a = 0; a < DISCARD_N + 10; a++) step(0, 1, 1, 1'($urandom_range(0, 1)), 0);
        step(0, 0, 1, 1, 0);
        for (int a = 0; a < DISCARD_N + WORD_W; a++) step(0, 1, 1, 1'($urandom_range(0, 1)), 0);
        chk("abort_fill", 32'(fill), 32'd3);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);

        // Repetition run of ones right after the discard window.
        step(1, 0, 0, 0, 0);
        for (int a = 0; a < DISCARD_N; a++) step(0, 1, 1, 1'($urandom_range(0, 1)), 0);
        for (int a = 0; a < WORD_W; a++) step(0, 1, 1, 1, 0);
`ifdef TRNG_PACKER_HEALTH_EN
        chk("rct_health", 32'(health_fail), 32'h1);
        chk("rct_no_word", 32'(fill), 32'h0);
`else
        chk("rct_health", 32'(health_fail), 32'h0);
        chk("rct_word", out_if.data, 32'hFFFFFFFF);
`endif

        // Randomized traffic with occasional run aborts.
        for (int a = 0; a < 3000; a++)
            step(0, ($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
